dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the processor core's load/store path and a debug/loader port. It sits between the core's memory signals (ALU address, register B write data, memread/memwrite) and the data memory. It owns grant, starvation-prevention and debug burst-lock state, and returns read data one cycle after acceptance. The core pauses its PC update on `core_stall`.

## Interface
Parameters:
- AW, 64, address width
- DW, 64, data width
- MAXWAIT, 4, max consecutive cycles a pending debug request may lose to the core (legal range 1..15)

Ports:
- CLK  in  1  clock; all state updates on posedge
- resetl  in  1  reset resetl, synchronous, active-high
- core_req  in  1  core requests a transfer this cycle
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  core address
- core_wdata  in  DW  core store data
- core_gnt  out  1  core transfer accepted this cycle (combinational)
- core_rdata  out  DW  registered load data
- core_rvalid  out  1  core_rdata valid (one cycle after a granted load)
- core_stall  out  1  core_req & ~core_gnt
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port request, same meaning as the core fields
- dbg_lock  in  1  debug requests exclusive ownership for a burst
- dbg_gnt, dbg_rdata, dbg_rvalid  out  1/DW/1  debug-side equivalents
- mem_read, mem_write  out  1/1  to data memory
- mem_addr, mem_wdata  out  AW/DW  to data memory
- mem_rdata  in  DW  combinational read data from memory

## Operation
- State machine, 2 states:
  - ARB: normal arbitration.
  - LOCKED: debug owns memory.
- ARB grant rule: the core wins if core_req and wait_cnt < MAXWAIT. Otherwise debug wins if dbg_req.
- At most one grant per cycle. No grant means mem_read = mem_write = 0, with addr/wdata driven to 0.
- Granted transfer: the winner's addr/wdata are driven to memory. mem_write = we and mem_read = ~we. Memory samples writes on the same posedge.
- wait_cnt (4-bit):
  - increments when dbg_req = 1 and dbg_gnt = 0, saturating at MAXWAIT;
  - clears on dbg_gnt or when dbg_req = 0.
- ARB -> LOCKED: on the edge ending a cycle with dbg_gnt & dbg_lock.
- LOCKED behaviour: dbg_gnt = dbg_req and core_gnt = 0, regardless of core_req. wait_cnt is held at 0.
- LOCKED -> ARB: on the first edge where dbg_lock = 0. A dbg_req in that same cycle is still granted.
- Read return: on a granted load, mem_rdata is registered into the winner's rdata, and that winner's rvalid pulses high for exactly one cycle. rdata holds its value until the next load for that port.
- Stores produce no rvalid.

## Timing
- Grant latency: 0 cycles, combinational from req and state.
- Load data latency: 1 cycle after grant.
- Back-to-back granted loads give back-to-back rvalid pulses.
- Reset values:
  - state = ARB, wait_cnt = 0;
  - core_rvalid = dbg_rvalid = 0, core_rdata = dbg_rdata = 0.
- All combinational outputs follow from the reset state.
- Reset asserted in the cycle after a granted load suppresses that rvalid.
- Reset during LOCKED returns to ARB on the next edge.
- Simultaneous requests with wait_cnt < MAXWAIT: core wins and debug waits.
- With wait_cnt == MAXWAIT: debug wins once, wait_cnt clears, then core priority resumes.
- dbg_lock asserted without dbg_gnt has no effect.
- Request inputs must be stable for the whole cycle.

## Structure
- Shared package `proc_pkg` holds:
  - state enum `arb_state_t` {ARB, LOCKED};
  - port index constants PORT_CORE = 0, PORT_DBG = 1;
  - the MAXWAIT default.
- One natural sub-module, `dmem_rd_return`: registers mem_rdata and generates the per-port rvalid from the granted-load winner index.
- Grant logic, wait counter and FSM live in the top level.

## Test plan
- Reset: hold resetl = 1 for 2 cycles with both reqs high. Required: all rvalid = 0, rdata = 0; after release, core_gnt = 1 on the first cycle.
- Core only: core store to addr 0x10 with data 0xDEAD_BEEF, then core load from 0x10. Required: mem_write pulse at 0x10; one cycle after the load grant, core_rvalid = 1 and core_rdata = 0xDEAD_BEEF; core_stall = 0 throughout.
- Starvation, MAXWAIT = 4: both request continuously. Required:
  - cycles 0–3: core_gnt;
  - cycle 4: dbg_gnt with core_stall = 1;
  - cycle 5: core_gnt again;
  - the pattern repeats every 5 cycles.
- Lock burst: dbg_req with dbg_lock for 6 cycles while core_req = 1, then dbg_lock drops. Required: dbg_gnt in all 6 cycles plus the lock-drop cycle, core_stall = 1 throughout, core_gnt on the following cycle.
- Reset mid-operation: granted dbg load, then resetl = 1 in the next cycle. Required: dbg_rvalid stays 0, and state is ARB after reset.
- Idle: no reqs. Required: mem_read = mem_write = 0, no gnt, wait_cnt remains 0.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the data-memory arbiter.
//   arb_state_t     - arbiter state (ARB: normal arbitration, LOCKED: debug owns memory)
//   PORT_CORE/DBG   - requester index used to steer read-return data
//   MAXWAIT_DEFAULT - default number of cycles a pending debug request may lose to the core
package proc_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int unsigned MAXWAIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: captures memory read data for the port that won a load and
// raises that port's rvalid for one cycle.
//   i_clk, i_resetl       - clock, synchronous active-high reset
//   i_load                - a load was granted this cycle
//   i_port                - winner index (PORT_CORE / PORT_DBG)
//   i_mem_rdata           - combinational read data from memory
//   o_core_rdata/_rvalid  - core-side return
//   o_dbg_rdata/_rvalid   - debug-side return
module dmem_rd_return
    import proc_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          i_clk,
    input  logic          i_resetl,
    input  logic          i_load,
    input  logic          i_port,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [DW-1:0] o_core_rdata,
    output logic          o_core_rvalid,
    output logic [DW-1:0] o_dbg_rdata,
    output logic          o_dbg_rvalid
);

    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_dbg_rdata;
    logic          r_core_rvalid;
    logic          r_dbg_rvalid;
    logic          w_core_load;
    logic          w_dbg_load;

    assign w_core_load = i_load && (i_port == PORT_CORE);
    assign w_dbg_load  = i_load && (i_port == PORT_DBG);

    always_ff @(posedge i_clk) begin
        if (i_resetl) begin
            r_core_rdata  <= '0;
            r_dbg_rdata   <= '0;
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_load;
            r_dbg_rvalid  <= w_dbg_load;
            if (w_core_load) r_core_rdata <= i_mem_rdata;
            if (w_dbg_load)  r_dbg_rdata  <= i_mem_rdata;
        end
    end

    // A reset arriving in the cycle after a granted load must hide the pending
    // pulse, so rvalid is masked while reset is asserted.
    assign o_core_rvalid = r_core_rvalid && !i_resetl;
    assign o_dbg_rvalid  = r_dbg_rvalid && !i_resetl;
    assign o_core_rdata  = r_core_rdata;
    assign o_dbg_rdata   = r_dbg_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path and a
// debug/loader port. Core has priority, but a pending debug request is granted
// after losing MAXWAIT consecutive cycles. A debug grant with dbg_lock held
// gives debug exclusive ownership until dbg_lock drops.
//   CLK, resetl                               - clock, synchronous active-high reset
//   core_req/we/addr/wdata -> core_gnt/stall  - core request, combinational grant
//   core_rdata/rvalid                         - core load return (1 cycle latency)
//   dbg_req/we/addr/wdata/lock -> dbg_gnt     - debug request, combinational grant
//   dbg_rdata/rvalid                          - debug load return (1 cycle latency)
//   mem_read/write/addr/wdata, mem_rdata      - data memory interface
module dmem_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT
) (
    input  logic          CLK,
    input  logic          resetl,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    output logic          core_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WaitMax = MAXWAIT[3:0];

    arb_state_t r_state;
    arb_state_t w_state_d;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_d;
    logic       w_core_gnt;
    logic       w_dbg_gnt;
    logic       w_any_gnt;
    logic       w_we;

    // Grant decode: purely combinational from the requests and current state.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (r_state == LOCKED) begin
            w_dbg_gnt = dbg_req;
        end else begin
            w_core_gnt = core_req && (r_wait_cnt < WaitMax);
            w_dbg_gnt  = dbg_req && !w_core_gnt;
        end
    end

    assign w_any_gnt = w_core_gnt || w_dbg_gnt;
    assign w_we      = w_core_gnt ? core_we : dbg_we;

    always_comb begin
        mem_read  = w_any_gnt && !w_we;
        mem_write = w_any_gnt && w_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Count consecutive cycles debug has been refused; saturate at the limit
    // so the forced debug win happens exactly once per starvation window.
    always_comb begin
        w_wait_cnt_d = '0;
        if (r_state == ARB && dbg_req && !w_dbg_gnt) begin
            w_wait_cnt_d = (r_wait_cnt < WaitMax) ? r_wait_cnt + 4'd1 : r_wait_cnt;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ARB:    if (w_dbg_gnt && dbg_lock) w_state_d = LOCKED;
            LOCKED: if (!dbg_lock) w_state_d = ARB;
            default: w_state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_state    <= ARB;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    assign core_gnt   = w_core_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign core_stall = core_req && !w_core_gnt;

    dmem_rd_return #(
        .DW (DW)
    ) u_rd_return (
        .i_clk         (CLK),
        .i_resetl      (resetl),
        .i_load        (mem_read),
        .i_port        (w_dbg_gnt ? PORT_DBG : PORT_CORE),
        .i_mem_rdata   (mem_rdata),
        .o_core_rdata  (core_rdata),
        .o_core_rvalid (core_rvalid),
        .o_dbg_rdata   (dbg_rdata),
        .o_dbg_rvalid  (dbg_rvalid)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int unsigned AW      = 64;
    localparam int unsigned DW      = 64;
    localparam int unsigned MAXWAIT = 4;

    logic          CLK = 1'b0;
    logic          resetl;
    logic          core_req, core_we, core_gnt, core_rvalid, core_stall;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Environment memory (256 words, indexed by low address byte)
    logic [DW-1:0] env_mem [256];
    assign mem_rdata = env_mem[mem_addr[7:0]];

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAXWAIT (MAXWAIT)
    ) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_lock    (dbg_lock),
        .dbg_gnt     (dbg_gnt),
        .dbg_rdata   (dbg_rdata),
        .dbg_rvalid  (dbg_rvalid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit            m_locked;
    int            m_wait;
    bit            m_core_rv, m_dbg_rv;
    logic [DW-1:0] m_core_rd, m_dbg_rd;
    logic [DW-1:0] ref_mem [256];

    task automatic step(input logic rst,
                        input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [63:0] da, input logic [63:0] dd);
        bit            e_cg, e_dg, e_we;
        logic [63:0]   e_addr, e_wdata;
        logic          s_wr;
        logic [63:0]   s_addr, s_wdata;
        @(negedge CLK);
        resetl = rst; core_req = cr; core_we = rst ? 1'b0 : cw; core_addr = ca; core_wdata = cd;
        dbg_req = dr; dbg_we = rst ? 1'b0 : dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
        #1;
        e_cg = !m_locked && cr && (m_wait < int'(MAXWAIT));
        e_dg = m_locked ? dr : (dr && !e_cg);
        e_we = e_cg ? core_we : dbg_we;
        e_addr = e_cg ? ca : (e_dg ? da : 64'h0);
        e_wdata = e_cg ? cd : (e_dg ? dd : 64'h0);
        if (!rst) begin
            check_val("core_gnt", core_gnt, e_cg);
            check_val("dbg_gnt", dbg_gnt, e_dg);
            check_val("core_stall", core_stall, cr && !e_cg);
            check_val("mem_read", mem_read, (e_cg || e_dg) && !e_we);
            check_val("mem_write", mem_write, (e_cg || e_dg) && e_we);
            check_val("mem_addr", mem_addr, e_addr);
            check_val("mem_wdata", mem_wdata, e_wdata);
        end
        check_val("core_rvalid", core_rvalid, m_core_rv && !rst);
        check_val("dbg_rvalid", dbg_rvalid, m_dbg_rv && !rst);
        check_val("core_rdata", core_rdata, m_core_rd);
        check_val("dbg_rdata", dbg_rdata, m_dbg_rd);
        check_val("wait_cnt", 64'(dut.r_wait_cnt), 64'(m_wait));
        check_val("locked", 64'(dut.r_state), 64'(m_locked));
        s_wr = mem_write; s_addr = mem_addr; s_wdata = mem_wdata;
        @(posedge CLK);
        #1;
        if (s_wr) env_mem[s_addr[7:0]] = s_wdata;
        if (rst) begin
            m_locked = 0; m_wait = 0; m_core_rv = 0; m_dbg_rv = 0;
            m_core_rd = '0; m_dbg_rd = '0;
        end else begin
            m_core_rv = e_cg && !e_we;
            m_dbg_rv  = e_dg && !e_we;
            if (m_core_rv) m_core_rd = ref_mem[e_addr[7:0]];
            if (m_dbg_rv)  m_dbg_rd  = ref_mem[e_addr[7:0]];
            if ((e_cg || e_dg) && e_we) ref_mem[e_addr[7:0]] = e_wdata;
            if (m_locked || !dr || e_dg) m_wait = 0;
            else if (m_wait < int'(MAXWAIT)) m_wait++;
            m_locked = m_locked ? bit'(dl) : bit'(e_dg && dl);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        m_locked = 0; m_wait = 0; m_core_rv = 0; m_dbg_rv = 0; m_core_rd = '0; m_dbg_rd = '0;
        resetl = 1; core_req = 1; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;

        // Reset with both requests high, then core must win first
        step(1, 1, 0, 64'h20, 0, 1, 0, 0, 64'h30, 0);
        step(1, 1, 0, 64'h20, 0, 1, 0, 0, 64'h30, 0);
        step(0, 1, 0, 64'h20, 0, 1, 0, 0, 64'h30, 0);
        check_val("post_rst_core_gnt_seen", 64'(m_wait), 64'd1);
        idle(1);

        // Core store then load
        step(0, 1, 1, 64'h10, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step(0, 1, 0, 64'h10, 0, 0, 0, 0, 0, 0);
        idle(1);
        check_val("beef_ref", m_core_rd, 64'hDEAD_BEEF);

        // Starvation: both requesting continuously
        for (int i = 0; i < 15; i++)
            step(0, 1, 0, 64'(i), 0, 1, 0, 0, 64'(i + 32), 0);
        idle(1);

        // Lock burst: debug wins after starvation window, then holds the lock
        for (int i = 0; i < 5 + 6; i++)
            step(0, 1, 0, 64'h1, 0, 1, 1, 1, 64'(i + 64), 64'(i * 3 + 7));
        step(0, 1, 0, 64'h1, 0, 1, 0, 0, 64'h40, 0);
        step(0, 1, 0, 64'h1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Debug load granted, reset in the next cycle
        step(0, 0, 0, 0, 0, 1, 0, 0, 64'h40, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Reset while locked
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1, 0, 1, 64'h41, 0);
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] ca, da;
            ca = {32'($urandom), 28'h0, 4'($urandom_range(0, 15))};
            da = {32'($urandom), 28'h0, 4'($urandom_range(0, 15))};
            step(($urandom_range(0, 63) == 0),
                 1'($urandom), 1'($urandom), ca, {$urandom, $urandom},
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 da, {$urandom, $urandom});
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
